// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states and the two-valued port identifier.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } arb_state_t;

  typedef logic port_t;

  localparam port_t PORT_CPU = 1'b0;
  localparam port_t PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way request picker: a lone requester wins, and a tie goes to the
// port that did not own the bus last (round-robin) or always to the CPU port.
module rr_pick2
  import sram_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic  req0,
  input  logic  req1,
  input  port_t last_owner,
  output logic  valid,
  output port_t owner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      owner = ROUND_ROBIN ? ~last_owner : PORT_CPU;
    end else if (req1) begin
      owner = PORT_LDR;
    end else begin
      owner = PORT_CPU;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM port between the CPU memory path (port 0) and a
// loader/debug master (port 1): arbitrate, hold a programmable strobe, capture, recover.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        OE,
  output logic        WE,
  output logic [1:0]  dbg_state
);

  // Requester handshake: a master raises reqN with weN/addrN/wdataN stable and keeps
  // them until gntN pulses for one cycle (request latched, inputs free to change);
  // doneN pulses for one cycle when the access has finished (rdata valid on reads).
  // reqN must be low again within one cycle after doneN or the access is repeated.

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  arb_state_t  state;
  port_t       owner;
  port_t       last_owner;
  logic        cur_we;
  logic [3:0]  wait_cnt;

  logic        pick_valid;
  port_t       pick_owner;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;

  rr_pick2 #(
    .ROUND_ROBIN (ROUND_ROBIN != 0)
  ) u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    sel_we    = (pick_owner == PORT_LDR) ? we1    : we0;
    sel_addr  = (pick_owner == PORT_LDR) ? addr1  : addr0;
    sel_wdata = (pick_owner == PORT_LDR) ? wdata1 : wdata0;
  end

  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (!Reset_al) begin
      state        <= S_IDLE;
      owner        <= PORT_CPU;
      last_owner   <= PORT_LDR;
      cur_we       <= 1'b0;
      wait_cnt     <= 4'd0;
      OE           <= 1'b1;
      WE           <= 1'b1;
      ADDR         <= 16'h0000;
      Data_to_SRAM <= 16'h0000;
      rdata        <= 16'h0000;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner        <= pick_owner;
            last_owner   <= pick_owner;
            cur_we       <= sel_we;
            ADDR         <= sel_addr;
            Data_to_SRAM <= sel_we ? sel_wdata : 16'h0000;
            OE           <= sel_we;
            WE           <= ~sel_we;
            wait_cnt     <= WAIT_LOAD;
            gnt0         <= (pick_owner == PORT_CPU);
            gnt1         <= (pick_owner == PORT_LDR);
            busy         <= 1'b1;
            state        <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Last strobe cycle: the SRAM output has settled, so capture it on reads.
            if (!cur_we) begin
              rdata <= Data_from_SRAM;
            end
            OE    <= 1'b1;
            WE    <= 1'b1;
            done0 <= (owner == PORT_CPU);
            done1 <= (owner == PORT_LDR);
            state <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          OE    <= 1'b1;
          WE    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single physical SRAM port (ADDR, Data_to_SRAM, Data_from_SRAM, OE, WE) between two masters:
  - port 0: the SLC-3 CPU memory path (MAR/MDR side of the memory subsystem);
  - port 1: a program-loader/debug master.
- Sequences each access: arbitration, a strobe window of programmable width, data capture, then a recovery cycle.
- Tie-break is round-robin or fixed priority.
- Sits between the requesters and the SRAM pins in the top level.

Parameters:
- WAIT_CYCLES, 2, extra cycles the OE/WE strobe is held beyond the first (0..15). Strobe width = WAIT_CYCLES+1 cycles.
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = port 0 always wins ties.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_al  in  1  synchronous, active-low reset.
- req0, req1  in  1 each  access request from port 0 / port 1.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  16 each  word address.
- wdata0, wdata1  in  16 each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse; request accepted and latched.
- done0, done1  out  1 each  one-cycle pulse; access complete, rdata valid.
- rdata  out  16  read data; holds until next read completes.
- busy  out  1  high in every state except IDLE.
- ADDR  out  16  SRAM address.
- Data_to_SRAM  out  16  SRAM write data.
- Data_from_SRAM  in  16  SRAM read data.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.

Behaviour:
- Reset values (Reset_al low at an edge): state IDLE; OE=1, WE=1; ADDR=0, Data_to_SRAM=0, rdata=0; gnt*, done*, busy = 0; wait counter = 0; last_owner = 1, so port 0 wins the first tie.
- Reset mid-access: aborts at that edge. Strobes deassert, no done is issued, and the latched request is discarded.
- All outputs are registered.
- States: IDLE -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - At each edge, sample req0/req1.
  - If neither is high, stay in IDLE.
  - If exactly one is high, select that port.
  - If both are high, select !last_owner when ROUND_ROBIN=1, else port 0.
  - On selection: latch owner, we, addr and wdata; set last_owner = owner; load counter = WAIT_CYCLES; go to ACCESS; pulse gnt<owner> for the next cycle.
- ACCESS:
  - ADDR = latched addr.
  - Read: OE=0, WE=1, Data_to_SRAM=0.
  - Write: WE=0, OE=1, Data_to_SRAM = latched wdata.
  - If counter != 0, decrement.
  - If counter == 0 at an edge: on a read, rdata <= Data_from_SRAM. Then go to RECOVER, set OE=WE=1, and pulse done<owner>.
- RECOVER:
  - Lasts exactly one cycle, strobes high, with ADDR and Data_to_SRAM held.
  - Next edge goes to IDLE. Requests are not sampled in RECOVER.
- Timing (WAIT_CYCLES=2, request sampled at edge e0):
  - gnt high e0..e1.
  - Strobe low e0..e3.
  - rdata updated at e3; done high e3..e4.
  - IDLE from e4; next sample at e5.
  - Throughput is one access per WAIT_CYCLES+3 cycles.
- Requester contract:
  - Hold req/we/addr/wdata stable until gnt.
  - The arbiter's copy is fixed once gnt is issued.
  - Deassert req within one cycle after done, or the request is re-serviced.
  - A req dropped before it is sampled in IDLE produces no access.
- Writes do not modify rdata.
- done and gnt are never asserted for both ports in the same cycle.
- WAIT_CYCLES=0: single-cycle strobe, done at e1.
- The counter is 4 bits; no wrap, since decrement stops at 0.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} arb_state_t;
  - typedef logic port_t;
  - localparam PORT_CPU = 1'b0, PORT_LDR = 1'b1.
- Sub-module rr_pick2: combinational two-way pick.
  - Inputs: req0, req1, last_owner, ROUND_ROBIN.
  - Outputs: valid, owner.
  - Used by the IDLE logic.

Test Plan:
- Reset, then CPU read: req0=1, we0=0, addr0=16'h0042, SRAM model returns 16'hBEEF -> gnt0 one cycle after e0; OE low 3 cycles; done0 at e3 with rdata=16'hBEEF; WE stays 1.
- Loader write: req1=1, we1=1, addr1=16'h1234, wdata1=16'hA5A5 -> WE low 3 cycles; ADDR=16'h1234; Data_to_SRAM=16'hA5A5; done1 pulse; rdata unchanged.
- Simultaneous requests from reset, held through 4 transactions, ROUND_ROBIN=1 -> grants alternate 0,1,0,1; each transaction 5 cycles apart.
- Same stimulus with ROUND_ROBIN=0 -> all four grants to port 0; port 1 served only after req0 drops.
- Reset_al low at the second ACCESS cycle of a read -> next cycle OE=1, busy=0, no done; a subsequent req1 is served normally.
- WAIT_CYCLES=0, back-to-back reads of 16'h0000 and 16'hFFFF -> 1-cycle strobe; done one edge after grant; correct rdata each time; 3-cycle spacing.
